// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I definitions for the memory-access stage.
//   - opcode constants used by writeback decode
//   - load/store funct3 size codes
//   - mem_state_t: memory-stage FSM states (IDLE/REQ/WAIT)
//   - helpers: opcode_writes_rd, funct3_valid
package rv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  // Opcodes that architecturally write rd (rd==x0 is handled by the caller).
  function automatic logic opcode_writes_rd(input logic [6:0] opc);
    logic w;
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_JAL,
      OPC_JALR, OPC_LUI, OPC_AUIPC: w = 1'b1;
      default:                      w = 1'b0;
    endcase
    return w;
  endfunction

  // Legal funct3 encodings: loads B/H/W/BU/HU, stores B/H/W.
  function automatic logic funct3_valid(input logic is_load, input logic [2:0] f3);
    logic ok;
    if (is_load) begin
      case (f3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
        default:                        ok = 1'b0;
      endcase
    end else begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    return ok;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: combinational load-data extraction and extension.
//   rdata_i  [31:0] raw word returned by data memory
//   funct3_i [2:0]  load size/signedness (LB/LH/LW/LBU/LHU)
//   lane_i   [1:0]  byte offset of the access within the word
//   data_o   [31:0] aligned, sign/zero-extended load value (0 for illegal funct3)
// The word is shifted down by the full byte offset, so misaligned halfword and
// word loads see zeros in the lanes beyond bit 31.
module mem_load_align
  import rv_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {lane_i, 3'b000};
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data_o = {24'h000000, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data_o = {16'h0000, shifted[15:0]};
      F3_W:    data_o = shifted;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage (EX/MEM -> data memory -> writeback).
//   Upstream : in_valid/in_ready handshake with pc, opcode, funct3, rd,
//              alu_res (address or pass-through value), data_rs2 (store data).
//   Dmem     : dmem_req/we/addr/be/wdata out, dmem_gnt/rvalid/rdata in.
//              addr/we/be/wdata are held stable while dmem_req waits for gnt.
//   Writeback: registered one-cycle packet wb_valid/wb_we/wb_rd/wb_data plus
//              misalign_exc; all zero outside the wb_valid cycle.
// Build option: define MEM_MISALIGN_CHECK_EN to trap misaligned halfword/word
// accesses (no request, misalign_exc with the writeback pulse). Without it,
// misaligned accesses are issued with byte enables shifted and truncated.
module mem_stage
  import rv_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       pc,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rd,
  input  logic [31:0]       alu_res,
  input  logic [31:0]       data_rs2,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              misalign_exc
);

  mem_state_t state_q;

  // Instruction context kept across the memory access.
  logic [4:0]  rd_q;
  logic [2:0]  funct3_q;
  logic [31:0] alu_q;
  logic        rd_we_q;

  logic              dmem_req_q;
  logic              dmem_we_q;
  logic [ADDR_W-1:0] dmem_addr_q;
  logic [3:0]        dmem_be_q;
  logic [31:0]       dmem_wdata_q;

  logic        wb_valid_q;
  logic        wb_we_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        misalign_q;

  // Decode of the instruction presented at the input.
  logic        is_load;
  logic        is_store;
  logic        f3_ok;
  logic        trap;
  logic        issue;
  logic        wb_we_d;
  logic [7:0]  be_wide;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] nonmem_data;
  logic [31:0] load_data;

`ifdef MEM_MISALIGN_CHECK_EN
  assign trap = (is_load || is_store) && f3_ok &&
                (((funct3[1:0] == 2'd1) && alu_res[0]) ||
                 ((funct3[1:0] == 2'd2) && (alu_res[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    is_load  = (opcode == OPC_LOAD);
    is_store = (opcode == OPC_STORE);
    f3_ok    = funct3_valid(is_load, funct3);
    issue    = (is_load || is_store) && f3_ok && !trap;
    // Loads/stores that are not issued (illegal funct3 or trapped) never write rd.
    wb_we_d  = opcode_writes_rd(opcode) && (rd != 5'd0) && !is_load;

    // Enables shift by the full byte offset; bits pushed past lane 3 are dropped.
    case (funct3[1:0])
      2'd0:    be_wide = 8'b0000_0001;
      2'd1:    be_wide = 8'b0000_0011;
      default: be_wide = 8'b0000_1111;
    endcase
    be_wide = be_wide << alu_res[1:0];
    be_d    = be_wide[3:0];

    case (funct3[1:0])
      2'd0:    wdata_d = {4{data_rs2[7:0]}};
      2'd1:    wdata_d = {2{data_rs2[15:0]}};
      default: wdata_d = data_rs2;
    endcase

    if ((opcode == OPC_JAL) || (opcode == OPC_JALR)) begin
      nonmem_data = pc + 32'd4;
    end else begin
      nonmem_data = alu_res;
    end
  end

  mem_load_align u_load_align (
    .rdata_i  (dmem_rdata),
    .funct3_i (funct3_q),
    .lane_i   (alu_q[1:0]),
    .data_o   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_q         <= '0;
      funct3_q     <= '0;
      alu_q        <= '0;
      rd_we_q      <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= '0;
      dmem_wdata_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      misalign_q   <= 1'b0;
    end else begin
      // Writeback packet is a single-cycle pulse, zero otherwise.
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (issue) begin
              state_q      <= REQ;
              rd_q         <= rd;
              funct3_q     <= funct3;
              alu_q        <= alu_res;
              rd_we_q      <= is_load && (rd != 5'd0);
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= is_store;
              dmem_addr_q  <= {alu_res[ADDR_W-1:2], 2'b00};
              dmem_be_q    <= be_d;
              dmem_wdata_q <= is_store ? wdata_d : '0;
            end else begin
              wb_valid_q <= 1'b1;
              wb_we_q    <= wb_we_d;
              wb_rd_q    <= rd;
              wb_data_q  <= nonmem_data;
              misalign_q <= trap;
            end
          end
        end

        REQ: begin
          if (dmem_gnt) begin
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= '0;
            dmem_wdata_q <= '0;
            if (dmem_we_q) begin
              state_q    <= IDLE;
              wb_valid_q <= 1'b1;
              wb_rd_q    <= rd_q;
              wb_data_q  <= alu_q;
            end else begin
              state_q <= WAIT;
            end
          end
        end

        WAIT: begin
          if (dmem_rvalid) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b1;
            wb_we_q    <= rd_we_q;
            wb_rd_q    <= rd_q;
            wb_data_q  <= load_data;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_be      = dmem_be_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_we        = wb_we_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign misalign_exc = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] pc = '0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd = '0;
  logic [31:0] alu_res = '0;
  logic [31:0] data_rs2 = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_exc;

  int unsigned total = 0;
  int unsigned bad   = 0;

  mem_stage #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pc           (pc),
    .opcode       (opcode),
    .funct3       (funct3),
    .rd           (rd),
    .alu_res      (alu_res),
    .data_rs2     (data_rs2),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .wb_valid     (wb_valid),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .misalign_exc (misalign_exc)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, OPIMM = 7'h13, OPR = 7'h33,
                         LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67,
                         BRANCH = 7'h63, SYSTEM = 7'h73;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model (spec arithmetic) ----
  function automatic bit m_writes(input logic [6:0] opc);
    return (opc == OPR) || (opc == OPIMM) || (opc == LOAD) || (opc == JAL) ||
           (opc == JALR) || (opc == LUI) || (opc == AUIPC);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [2:0] f3,
                                         input logic [1:0] lane);
    logic [31:0] s;
    logic [31:0] v;
    s = rdata >> (8 * lane);
    case (f3)
      3'd0: begin v = s % 256;   if (v >= 128)   v = v + 32'hFFFFFF00; end
      3'd4: v = s % 256;
      3'd1: begin v = s % 65536; if (v >= 32768) v = v + 32'hFFFF0000; end
      3'd5: v = s % 65536;
      default: v = s;
    endcase
    return v;
  endfunction

  // One instruction end to end; returns with the bench #1 after the wb_valid edge.
  task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rdi,
                        input logic [31:0] pci, input logic [31:0] alu, input logic [31:0] rs2,
                        input int unsigned gdly, input int unsigned rdly,
                        input logic [31:0] rdata);
    bit mem, ld, ok, mis, trapx, iss;
    int unsigned size, be_i;
    logic [31:0] exp_wd;
    mem   = (opc == LOAD) || (opc == STORE);
    ld    = (opc == LOAD);
    ok    = ld ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 <= 2);
    size  = f3 % 4;
    mis   = (size == 1 && alu[0]) || (size == 2 && alu % 4 != 0);
    trapx = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    trapx = mem && ok && mis;
`endif
    iss   = mem && ok && !trapx;

    check("in_ready_before", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; opcode = opc; funct3 = f3; rd = rdi; pc = pci;
    alu_res = alu; data_rs2 = rs2;
    tick();
    in_valid = 1'b0; opcode = $urandom; alu_res = $urandom; data_rs2 = $urandom;
    pc = $urandom; rd = $urandom; funct3 = $urandom;

    if (!iss) begin
      check("nomem_wb_valid", {31'd0, wb_valid}, 32'd1);
      check("nomem_wb_we", {31'd0, wb_we}, {31'd0, !mem && m_writes(opc) && rdi != 0});
      check("nomem_wb_rd", {27'd0, wb_rd}, {27'd0, rdi});
      check("nomem_misalign", {31'd0, misalign_exc}, {31'd0, trapx});
      check("nomem_no_req", {31'd0, dmem_req}, 32'd0);
      if (!mem) check("nomem_wb_data", wb_data, (opc == JAL || opc == JALR) ? pci + 4 : alu);
    end else begin
      be_i   = (((size == 0) ? 1 : (size == 1) ? 3 : 15) << (alu % 4)) % 16;
      exp_wd = (size == 0) ? (rs2 % 256) * 32'h01010101 :
               (size == 1) ? (rs2 % 65536) * 32'h00010001 : rs2;
      for (int k = 0; k <= int'(gdly); k++) begin
        check("req_req", {31'd0, dmem_req}, 32'd1);
        check("req_addr", dmem_addr, alu & 32'hFFFFFFFC);
        check("req_we", {31'd0, dmem_we}, {31'd0, !ld});
        if (!ld) begin
          check("req_be", {28'd0, dmem_be}, be_i);
          check("req_wdata", dmem_wdata, exp_wd);
        end
        check("req_in_ready", {31'd0, in_ready}, 32'd0);
        check("req_wb_quiet", {wb_valid, wb_we, wb_rd, misalign_exc} == 0 && wb_data == 0, 32'd1);
        dmem_rvalid = 1'b1;          // must be ignored outside WAIT
        dmem_rdata  = $urandom;
        if (k == int'(gdly)) dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      end
      if (!ld) begin
        check("st_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("st_wb_we", {31'd0, wb_we}, 32'd0);
        check("st_wb_rd", {27'd0, wb_rd}, {27'd0, rdi});
        check("st_wb_data", wb_data, alu);
        check("st_req_off", {31'd0, dmem_req}, 32'd0);
        check("st_in_ready", {31'd0, in_ready}, 32'd1);
      end else begin
        for (int k = 0; k <= int'(rdly); k++) begin
          check("wait_req_off", {31'd0, dmem_req}, 32'd0);
          check("wait_wb_valid", {31'd0, wb_valid}, 32'd0);
          check("wait_in_ready", {31'd0, in_ready}, 32'd0);
          if (k == int'(rdly)) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdata;
          end
          tick();
          dmem_rvalid = 1'b0; dmem_rdata = $urandom;
        end
        check("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("ld_wb_we", {31'd0, wb_we}, {31'd0, rdi != 0});
        check("ld_wb_rd", {27'd0, wb_rd}, {27'd0, rdi});
        check("ld_wb_data", wb_data, m_load(rdata, f3, alu[1:0]));
        check("ld_misalign", {31'd0, misalign_exc}, 32'd0);
        check("ld_in_ready", {31'd0, in_ready}, 32'd1);
      end
    end
  endtask

  // Start an LW, optionally get it granted, then reset asynchronously.
  task automatic reset_abort(input bit granted);
    in_valid = 1'b1; opcode = LOAD; funct3 = 3'd2; rd = 5'd9; alu_res = 32'h00004000;
    tick();
    in_valid = 1'b0;
    check("abort_req_up", {31'd0, dmem_req}, 32'd1);
    if (granted) begin
      dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0;
      check("abort_in_wait", {31'd0, in_ready}, 32'd0);
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_req_drop", {31'd0, dmem_req}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_gnt = 1'b1; dmem_rdata = 32'h12345678;
    tick();
    dmem_rvalid = 1'b0; dmem_gnt = 1'b0;
    check("abort_no_wb", {31'd0, wb_valid}, 32'd0);
    check("abort_idle", {31'd0, in_ready}, 32'd1);
    check("abort_no_req", {31'd0, dmem_req}, 32'd0);
    tick();
    check("abort_no_wb2", {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    logic [6:0] opc_tab [10];
    logic [6:0] o;
    opc_tab = '{OPIMM, OPR, LUI, AUIPC, JAL, JALR, BRANCH, SYSTEM, LOAD, STORE};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_dmem", {dmem_req, dmem_we, dmem_be} == 0 && dmem_addr == 0 && dmem_wdata == 0, 32'd1);
    check("rst_wb", {wb_valid, wb_we, wb_rd, misalign_exc} == 0 && wb_data == 0, 32'd1);
    rst_n = 1'b1;
    tick();

    // ADDI
    run_op(OPIMM, 3'd0, 5'd5, 32'h0, 32'h00001234, 32'h0, 0, 0, 32'h0);
    check("addi_const", wb_data, 32'h00001234);

    // LB / LBU at byte lane 3
    run_op(LOAD, 3'd0, 5'd6, 32'h0, 32'h00001003, 32'h0, 0, 0, 32'h80AA5511);
    check("lb_const", wb_data, 32'hFFFFFF80);
    run_op(LOAD, 3'd4, 5'd7, 32'h0, 32'h00001003, 32'h0, 0, 0, 32'h80AA5511);
    check("lbu_const", wb_data, 32'h00000080);

    // SH with gnt withheld 3 cycles (req observed 4 cycles)
    run_op(STORE, 3'd1, 5'd0, 32'h0, 32'h00002002, 32'hDEADBEEF, 3, 0, 32'h0);

    // JAL writeback of pc+4, rd=0 suppression, pc wrap
    run_op(JAL, 3'd0, 5'd1, 32'h00000100, 32'h00000200, 32'h0, 0, 0, 32'h0);
    check("jal_const", wb_data, 32'h00000104);
    run_op(JAL, 3'd0, 5'd0, 32'h00000100, 32'h00000200, 32'h0, 0, 0, 32'h0);
    check("jal_rd0_we", {31'd0, wb_we}, 32'd0);
    run_op(JALR, 3'd0, 5'd3, 32'hFFFFFFFC, 32'h0, 32'h0, 0, 0, 32'h0);
    check("jalr_wrap", wb_data, 32'h00000000);

    // Misaligned LW (trapped when the check is built in, else shifted lanes)
    run_op(LOAD, 3'd2, 5'd8, 32'h0, 32'h00003001, 32'h0, 1, 2, 32'hA1B2C3D4);
`ifdef MEM_MISALIGN_CHECK_EN
    check("lw_mis_exc", {31'd0, misalign_exc}, 32'd1);
`else
    check("lw_mis_shift", wb_data, 32'h00A1B2C3);
`endif

    // Illegal funct3
    run_op(LOAD, 3'd3, 5'd4, 32'h0, 32'h100, 32'h0, 0, 0, 32'h0);
    run_op(STORE, 3'd5, 5'd4, 32'h0, 32'h100, 32'h1, 0, 0, 32'h0);

    // Asynchronous reset mid-access
    reset_abort(1'b1);
    reset_abort(1'b0);

    // Randomised instruction stream
    for (int i = 0; i < 300; i++) begin
      o = ($urandom_range(0, 9) == 0) ? 7'($urandom) : opc_tab[$urandom_range(0, 9)];
      if ($urandom_range(0, 2) == 0) o = ($urandom_range(0, 1) == 0) ? LOAD : STORE;
      run_op(o, 3'($urandom), ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
             $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipelined RV32I core, sitting directly downstream of the execute stage. It consumes the execute result (`alu_res`) as a load/store address or as a pass-through value, runs a request/grant/response handshake with the data memory, aligns and extends load data, and registers the writeback packet. While a memory access is outstanding it stalls the upstream pipeline.

## Interface
- `ADDR_W`, default 32: data-memory address width. `alu_res[ADDR_W-1:0]` is used, and bits [1:0] are cleared on `dmem_addr`.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  the EX/MEM inputs below hold a valid instruction.
- `in_ready`  out  1  stage accepts the instruction this cycle; equals (state==IDLE).
- `pc`  in  32  instruction PC.
- `opcode`  in  7  RV32I opcode.
- `funct3`  in  3  load/store size and signedness.
- `rd`  in  5  destination register.
- `alu_res`  in  32  execute result: effective address for load/store, value otherwise.
- `data_rs2`  in  32  store data.
- `dmem_req`  out  1  memory request.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  ADDR_W  word-aligned address.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  store data, lane-replicated.
- `dmem_gnt`  in  1  request accepted.
- `dmem_rvalid`  in  1  load data valid.
- `dmem_rdata`  in  32  load data.
- `wb_valid`  out  1  one-cycle writeback pulse.
- `wb_we`  out  1  register write enable.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  32  writeback value.
- `misalign_exc`  out  1  misaligned access; pulses together with `wb_valid`.

## Operation
- FSM states: IDLE, REQ, WAIT. Reset state is IDLE.
- **Acceptance:** an instruction is accepted when `in_valid && in_ready`. All fields are captured into internal registers.
- **Non-memory ops:** state stays IDLE. `wb_valid` is asserted the next cycle.
- **Loads and stores:** IDLE -> REQ.
  - In REQ, `dmem_req`=1 and addr/we/be/wdata are held stable until `dmem_gnt`.
  - Store: REQ -> IDLE on `dmem_gnt`.
  - Load: REQ -> WAIT on `dmem_gnt`; WAIT -> IDLE on `dmem_rvalid`.
- **Invalid funct3** (load 3/6/7, store ≥3): treated as a no-op. No request is issued; `wb_valid` is asserted with `wb_we`=0.
- **`wb_we`** = (rd≠0) and opcode ∈ {R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC}. Branch, store, ECALL and unknown opcodes give `wb_we`=0.
- **`wb_data`:**
  - JAL/JALR: `pc`+4, mod 2^32.
  - Loads: aligned load data.
  - All other ops: `alu_res`.
- **Load alignment** uses lane = `alu_res[1:0]`:
  - LB/LBU: byte at lane, sign- or zero-extended to 32 bits.
  - LH/LHU: halfword at lane[1], sign- or zero-extended.
  - LW: whole word.
- **Store lanes:**
  - SB: be=0001<<lane; wdata = byte replicated ×4.
  - SH: be=0011<<(2·lane[1]); wdata = halfword replicated ×2.
  - SW: be=1111; wdata = `data_rs2`.
- `dmem_rvalid` is honoured only in WAIT. It is ignored in IDLE and REQ.

## Timing
- **Reset values:** all outputs 0 except `in_ready`=1.
- **Asynchronous reset mid-access:** state -> IDLE immediately and `dmem_req` drops. A response arriving after reset is ignored. No `wb_valid` is produced for the aborted instruction.
- **Non-memory op** accepted at cycle N: `wb_valid` at N+1. Throughput is one instruction per cycle.
- **Memory op** accepted at N: `dmem_req` from N+1.
  - `dmem_gnt` at cycle G ≥ N+1; store `wb_valid` at G+1.
  - Load `dmem_rvalid` at R ≥ G+1; `wb_valid` at R+1.
- `in_ready`=0 from N+1 until the cycle in which `wb_valid` is asserted.
- `wb_*` and `misalign_exc` are registered. They are valid only while `wb_valid`=1 and are zero otherwise.

## Configuration
- **`MEM_MISALIGN_CHECK_EN` defined:** LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]≠0, issue no request. `wb_valid` is asserted the next cycle with `wb_we`=0 and `misalign_exc`=1.
- **`MEM_MISALIGN_CHECK_EN` undefined:** `misalign_exc` is tied to 0.
  - The access is issued with enables shifted by addr[1:0] and truncated to 4 bits; bytes crossing the word boundary are dropped.
  - Loads extract from the shifted lane, and lanes beyond bit 31 read as 0.

## Structure
- **Shared package `rv_pkg`:** opcode constants, load/store funct3 constants, and the `mem_state_t` enum (IDLE/REQ/WAIT).
- **Sub-module `mem_load_align`:** purely combinational. Inputs are rdata, funct3 and lane; output is the 32-bit extended value.
- **FSM, capture registers and store-lane logic** stay in `mem_stage`.

## Test plan
- ADDI: opcode 0010011, alu_res 0x00001234, rd 5 -> next cycle `wb_valid`=1, `wb_we`=1, `wb_rd`=5, `wb_data`=0x00001234, with no `dmem_req`.
- LB then LBU at alu_res 0x00001003, rdata 0x80AA5511, gnt in the first REQ cycle, rvalid one cycle later -> `dmem_addr`=0x1000, `wb_data`=0xFFFFFF80 for LB and 0x00000080 for LBU.
- SH at 0x00002002, rs2 0xDEADBEEF, gnt withheld 3 cycles -> `dmem_be`=1100, `dmem_wdata`=0xBEEFBEEF, req held stable 4 cycles, `in_ready`=0, `wb_valid` with `wb_we`=0 the cycle after gnt.
- JAL with pc 0x00000100, rd 1, alu_res 0x00000200 -> `wb_data`=0x00000104, `wb_we`=1; rd 0 -> `wb_we`=0.
- LW at 0x00003001 with `MEM_MISALIGN_CHECK_EN` -> no `dmem_req`, `misalign_exc`=1 and `wb_valid`=1 the next cycle.
- Load in WAIT, `rst_n` pulsed low, then rvalid -> `dmem_req`=0 during reset, state IDLE, no `wb_valid`, `in_ready`=1.
